// File: rtl/fpnew_pkg.sv
// FPU shared types plus the issue-controller state and request bundle.
// Imported by the issue controller and its timeout timer.
package fpnew_pkg;

  localparam int unsigned FLEN = 64;

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
    CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  typedef enum logic [2:0] {
    RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3,
    RMM = 3'd4, ROD = 3'd5, DYN = 3'd7
  } roundmode_e;

  typedef enum logic [2:0] {
    FP32 = 3'd0, FP64 = 3'd1, FP16 = 3'd2,
    FP8 = 3'd3, FP16ALT = 3'd4
  } fp_format_e;

  typedef enum logic [1:0] {
    INT8, INT16, INT32, INT64
  } int_format_e;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  typedef enum logic [1:0] {
    ISS_IDLE, ISS_ISSUE, ISS_WAIT, ISS_RESP
  } issue_state_e;

  typedef struct packed {
    logic [2:0][FLEN-1:0] operands;
    operation_e           op;
    logic                 op_mod;
    roundmode_e           rnd_mode;
    fp_format_e           src_fmt;
    fp_format_e           dst_fmt;
    int_format_e          int_fmt;
  } fpu_req_t;

endpackage

// File: rtl/fpu_issue_timer.sv
// Saturating WAIT-phase counter; expire_o is high while the count
// equals TimeoutCycles.
module fpu_issue_timer
  import fpnew_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 128
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(TimeoutCycles + 1);
  localparam logic [CW-1:0] Max = CW'(TimeoutCycles);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) cnt_d = '0;
    else if (en_i && cnt_q != Max) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == Max);

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue-side initiator for the FPU: one op in flight, timeout
// supervision, flush propagation and sticky accrued flags.
module fpu_issue_ctrl
  import fpnew_pkg::*;
#(
  parameter int unsigned Width         = 64,
  parameter type         TagType       = logic,
  parameter int unsigned TimeoutCycles = 128
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [2:0][Width-1:0]  req_operands_i,
  input  operation_e             req_op_i,
  input  logic                   req_op_mod_i,
  input  roundmode_e             req_rnd_mode_i,
  input  fp_format_e             req_src_fmt_i,
  input  fp_format_e             req_dst_fmt_i,
  input  int_format_e            req_int_fmt_i,
  input  TagType                 req_tag_i,
  output logic                   fpu_in_valid_o,
  input  logic                   fpu_in_ready_i,
  output logic [2:0][Width-1:0]  fpu_operands_o,
  output operation_e             fpu_op_o,
  output logic                   fpu_op_mod_o,
  output roundmode_e             fpu_rnd_mode_o,
  output fp_format_e             fpu_src_fmt_o,
  output fp_format_e             fpu_dst_fmt_o,
  output int_format_e            fpu_int_fmt_o,
  output TagType                 fpu_tag_o,
  input  logic                   fpu_out_valid_i,
  output logic                   fpu_out_ready_o,
  input  logic [Width-1:0]       fpu_result_i,
  input  status_t                fpu_status_i,
  input  TagType                 fpu_tag_i,
  output logic                   fpu_flush_o,
  input  logic                   flush_i,
  output logic                   wb_valid_o,
  input  logic                   wb_ready_i,
  output logic [Width-1:0]       wb_result_o,
  output status_t                wb_status_o,
  output TagType                 wb_tag_o,
  output logic [4:0]             fflags_o,
  input  logic                   fflags_clr_i,
  output logic                   timeout_o,
  output logic                   tag_err_o,
  output logic                   busy_o
);

  issue_state_e      state_q, state_d;
  fpu_req_t          req_q, req_d;
  TagType            tag_q, tag_d;
  logic [Width-1:0]  wb_result_q, wb_result_d;
  status_t           wb_status_q, wb_status_d;
  TagType            wb_tag_q, wb_tag_d;
  logic [4:0]        fflags_q, fflags_d;
  logic              flush_q, flush_d;
  logic              timeout_q, timeout_d;
  logic              tag_err_q, tag_err_d;
  logic              tmr_load, tmr_expire, tag_match;

  fpu_issue_timer #(
    .TimeoutCycles(TimeoutCycles)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (tmr_load),
    .en_i    (state_q == ISS_WAIT),
    .expire_o(tmr_expire)
  );

  assign tag_match = (fpu_tag_i == tag_q);

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    tag_d       = tag_q;
    wb_result_d = wb_result_q;
    wb_status_d = wb_status_q;
    wb_tag_d    = wb_tag_q;
    fflags_d    = fflags_q;
    flush_d     = 1'b0;
    timeout_d   = 1'b0;
    tag_err_d   = 1'b0;
    tmr_load    = 1'b0;
    if (fflags_clr_i) fflags_d = '0;
    case (state_q)
      ISS_IDLE: begin
        if (req_valid_i && !flush_i) begin
          req_d.operands = req_operands_i;
          req_d.op       = req_op_i;
          req_d.op_mod   = req_op_mod_i;
          req_d.rnd_mode = req_rnd_mode_i;
          req_d.src_fmt  = req_src_fmt_i;
          req_d.dst_fmt  = req_dst_fmt_i;
          req_d.int_fmt  = req_int_fmt_i;
          tag_d          = req_tag_i;
          state_d        = ISS_ISSUE;
        end
      end
      ISS_ISSUE: begin
        if (flush_i) begin
          flush_d = 1'b1;
          state_d = ISS_IDLE;
        end else if (fpu_in_ready_i) begin
          tmr_load = 1'b1;
          state_d  = ISS_WAIT;
        end
      end
      ISS_WAIT: begin
        if (flush_i) begin
          flush_d = 1'b1;
          state_d = ISS_IDLE;
        end else if (fpu_out_valid_i && tag_match) begin
          wb_result_d = fpu_result_i;
          wb_status_d = fpu_status_i;
          wb_tag_d    = fpu_tag_i;
          state_d     = ISS_RESP;
        end else begin
          tag_err_d = fpu_out_valid_i;
          // Abort the stuck op and report it as an invalid operation.
          if (tmr_expire) begin
            timeout_d   = 1'b1;
            flush_d     = 1'b1;
            wb_result_d = '0;
            wb_status_d = status_t'(5'b10000);
            wb_tag_d    = tag_q;
            state_d     = ISS_RESP;
          end
        end
      end
      ISS_RESP: begin
        if (flush_i) begin
          state_d = ISS_IDLE;
        end else if (wb_ready_i) begin
          fflags_d = fflags_d | wb_status_q;
          state_d  = ISS_IDLE;
        end
      end
      default: state_d = ISS_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ISS_IDLE;
      req_q       <= '0;
      tag_q       <= '0;
      wb_result_q <= '0;
      wb_status_q <= '0;
      wb_tag_q    <= '0;
      fflags_q    <= '0;
      flush_q     <= 1'b0;
      timeout_q   <= 1'b0;
      tag_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      tag_q       <= tag_d;
      wb_result_q <= wb_result_d;
      wb_status_q <= wb_status_d;
      wb_tag_q    <= wb_tag_d;
      fflags_q    <= fflags_d;
      flush_q     <= flush_d;
      timeout_q   <= timeout_d;
      tag_err_q   <= tag_err_d;
    end
  end

  assign req_ready_o     = (state_q == ISS_IDLE) && !flush_i && !rst_i;
  assign fpu_in_valid_o  = (state_q == ISS_ISSUE);
  assign fpu_out_ready_o = (state_q == ISS_WAIT);
  assign wb_valid_o      = (state_q == ISS_RESP);
  assign busy_o          = (state_q != ISS_IDLE);
  assign fpu_operands_o  = req_q.operands;
  assign fpu_op_o        = req_q.op;
  assign fpu_op_mod_o    = req_q.op_mod;
  assign fpu_rnd_mode_o  = req_q.rnd_mode;
  assign fpu_src_fmt_o   = req_q.src_fmt;
  assign fpu_dst_fmt_o   = req_q.dst_fmt;
  assign fpu_int_fmt_o   = req_q.int_fmt;
  assign fpu_tag_o       = tag_q;
  assign wb_result_o     = wb_result_q;
  assign wb_status_o     = wb_status_q;
  assign wb_tag_o        = wb_tag_q;
  assign fflags_o        = fflags_q;
  assign fpu_flush_o     = flush_q;
  assign timeout_o       = timeout_q;
  assign tag_err_o       = tag_err_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: basic op, backpressure, timeout,
// flush, tag mismatch and asynchronous reset.
module tb_fpu_issue_ctrl;
  import fpnew_pkg::*;

  typedef logic [3:0] tag_t;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              req_valid_i, req_ready_o;
  logic [2:0][63:0]  req_operands_i;
  operation_e        req_op_i;
  logic              req_op_mod_i;
  roundmode_e        req_rnd_mode_i;
  fp_format_e        req_src_fmt_i, req_dst_fmt_i;
  int_format_e       req_int_fmt_i;
  tag_t              req_tag_i;
  logic              fpu_in_valid_o, fpu_in_ready_i;
  logic [2:0][63:0]  fpu_operands_o;
  operation_e        fpu_op_o;
  logic              fpu_op_mod_o;
  roundmode_e        fpu_rnd_mode_o;
  fp_format_e        fpu_src_fmt_o, fpu_dst_fmt_o;
  int_format_e       fpu_int_fmt_o;
  tag_t              fpu_tag_o;
  logic              fpu_out_valid_i, fpu_out_ready_o;
  logic [63:0]       fpu_result_i;
  status_t           fpu_status_i;
  tag_t              fpu_tag_i;
  logic              fpu_flush_o, flush_i;
  logic              wb_valid_o, wb_ready_i;
  logic [63:0]       wb_result_o;
  status_t           wb_status_o;
  tag_t              wb_tag_o;
  logic [4:0]        fflags_o;
  logic              fflags_clr_i, timeout_o, tag_err_o, busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(
    .Width(64), .TagType(tag_t), .TimeoutCycles(8)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_operands_i(req_operands_i), .req_op_i(req_op_i),
    .req_op_mod_i(req_op_mod_i), .req_rnd_mode_i(req_rnd_mode_i),
    .req_src_fmt_i(req_src_fmt_i), .req_dst_fmt_i(req_dst_fmt_i),
    .req_int_fmt_i(req_int_fmt_i), .req_tag_i(req_tag_i),
    .fpu_in_valid_o(fpu_in_valid_o), .fpu_in_ready_i(fpu_in_ready_i),
    .fpu_operands_o(fpu_operands_o), .fpu_op_o(fpu_op_o),
    .fpu_op_mod_o(fpu_op_mod_o), .fpu_rnd_mode_o(fpu_rnd_mode_o),
    .fpu_src_fmt_o(fpu_src_fmt_o), .fpu_dst_fmt_o(fpu_dst_fmt_o),
    .fpu_int_fmt_o(fpu_int_fmt_o), .fpu_tag_o(fpu_tag_o),
    .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o),
    .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i),
    .fpu_tag_i(fpu_tag_i), .fpu_flush_o(fpu_flush_o),
    .flush_i(flush_i), .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_result_o(wb_result_o), .wb_status_o(wb_status_o),
    .wb_tag_o(wb_tag_o), .fflags_o(fflags_o),
    .fflags_clr_i(fflags_clr_i), .timeout_o(timeout_o),
    .tag_err_o(tag_err_o), .busy_o(busy_o)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input tag_t t);
    req_valid_i = 1'b1;
    req_tag_i   = t;
    tick();
    req_valid_i = 1'b0;
    fpu_in_ready_i = 1'b1;
    tick();
    fpu_in_ready_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    req_valid_i = 0; fpu_in_ready_i = 0; fpu_out_valid_i = 0;
    flush_i = 0; wb_ready_i = 0; fflags_clr_i = 0;
    req_operands_i = '0;
    req_operands_i[0] = 64'h3FF0000000000000;
    req_operands_i[1] = 64'h4000000000000000;
    req_op_i = ADD; req_op_mod_i = 0; req_rnd_mode_i = RNE;
    req_src_fmt_i = FP64; req_dst_fmt_i = FP64; req_int_fmt_i = INT32;
    req_tag_i = '0; fpu_result_i = '0; fpu_status_i = '0; fpu_tag_i = '0;
    #12;
    chk("rst_ready", 64'(req_ready_o), 0);
    chk("rst_busy", 64'(busy_o), 0);
    chk("rst_wbv", 64'(wb_valid_o), 0);
    chk("rst_fflags", 64'(fflags_o), 0);
    rst_i = 1'b0;
    tick();
    chk("idle_ready", 64'(req_ready_o), 1);

    // basic ADD, tag 5
    req_valid_i = 1'b1; req_tag_i = 4'd5;
    tick();
    req_valid_i = 1'b0;
    chk("iss_valid", 64'(fpu_in_valid_o), 1);
    chk("iss_opa", fpu_operands_o[0], 64'h3FF0000000000000);
    chk("iss_opb", fpu_operands_o[1], 64'h4000000000000000);
    chk("iss_tag", 64'(fpu_tag_o), 5);
    chk("iss_op", 64'(fpu_op_o), 64'(ADD));
    chk("iss_rdy", 64'(req_ready_o), 0);
    fpu_in_ready_i = 1'b1;
    tick();
    fpu_in_ready_i = 1'b0;
    chk("wait_inv", 64'(fpu_in_valid_o), 0);
    chk("wait_ordy", 64'(fpu_out_ready_o), 1);
    tick(); tick();
    fpu_out_valid_i = 1; fpu_result_i = 64'h4008000000000000;
    fpu_tag_i = 4'd5; fpu_status_i = '0;
    tick();
    fpu_out_valid_i = 0;
    chk("wb_valid", 64'(wb_valid_o), 1);
    chk("wb_res", wb_result_o, 64'h4008000000000000);
    chk("wb_tag", 64'(wb_tag_o), 5);
    chk("wb_stat", 64'(wb_status_o), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_valid", 64'(wb_valid_o), 1);
      chk("bp_res", wb_result_o, 64'h4008000000000000);
      chk("bp_rdy", 64'(req_ready_o), 0);
    end
    wb_ready_i = 1;
    tick();
    wb_ready_i = 0;
    chk("hs_wbv", 64'(wb_valid_o), 0);
    chk("hs_fflags", 64'(fflags_o), 0);
    chk("hs_ready", 64'(req_ready_o), 1);

    // timeout, tag 2
    send(4'd2);
    for (int i = 0; i < 8; i++) begin
      chk("to_early", 64'(timeout_o), 0);
      tick();
    end
    chk("to_early", 64'(timeout_o), 0);
    tick();
    chk("to_pulse", 64'(timeout_o), 1);
    chk("to_flush", 64'(fpu_flush_o), 1);
    chk("to_wbv", 64'(wb_valid_o), 1);
    chk("to_res", wb_result_o, 0);
    chk("to_stat", 64'(wb_status_o), 64'h10);
    chk("to_tag", 64'(wb_tag_o), 2);
    tick();
    chk("to_once", 64'(timeout_o), 0);
    chk("to_fl_once", 64'(fpu_flush_o), 0);
    wb_ready_i = 1;
    tick();
    wb_ready_i = 0;
    chk("to_fflags", 64'(fflags_o), 64'h10);

    // flush in WAIT cycle 2 with a colliding result
    send(4'd1);
    tick();
    flush_i = 1; fpu_out_valid_i = 1; fpu_tag_i = 4'd1;
    tick();
    flush_i = 0; fpu_out_valid_i = 0;
    chk("fl_pulse", 64'(fpu_flush_o), 1);
    chk("fl_wbv", 64'(wb_valid_o), 0);
    chk("fl_busy", 64'(busy_o), 0);
    tick();
    chk("fl_once", 64'(fpu_flush_o), 0);
    chk("fl_wbv2", 64'(wb_valid_o), 0);
    chk("fl_fflags", 64'(fflags_o), 64'h10);

    // tag mismatch then match; clear with handshake
    send(4'd3);
    fpu_out_valid_i = 1; fpu_tag_i = 4'd7; fpu_result_i = 64'h1;
    tick();
    fpu_out_valid_i = 0;
    chk("te_pulse", 64'(tag_err_o), 1);
    chk("te_wbv", 64'(wb_valid_o), 0);
    chk("te_busy", 64'(busy_o), 1);
    tick();
    chk("te_once", 64'(tag_err_o), 0);
    fpu_out_valid_i = 1; fpu_tag_i = 4'd3;
    fpu_result_i = 64'hC000000000000000; fpu_status_i = status_t'(5'b00100);
    tick();
    fpu_out_valid_i = 0;
    chk("te_wbv2", 64'(wb_valid_o), 1);
    chk("te_tag", 64'(wb_tag_o), 3);
    chk("te_res", wb_result_o, 64'hC000000000000000);
    wb_ready_i = 1; fflags_clr_i = 1;
    tick();
    wb_ready_i = 0; fflags_clr_i = 0;
    chk("clr_fflags", 64'(fflags_o), 64'h04);

    // asynchronous reset mid-ISSUE
    req_valid_i = 1; req_tag_i = 4'd9;
    tick();
    req_valid_i = 0;
    chk("ar_inv", 64'(fpu_in_valid_o), 1);
    #2 rst_i = 1;
    #1;
    chk("ar_inv0", 64'(fpu_in_valid_o), 0);
    chk("ar_busy", 64'(busy_o), 0);
    chk("ar_tag", 64'(fpu_tag_o), 0);
    chk("ar_ops", fpu_operands_o[0], 0);
    chk("ar_fflags", 64'(fflags_o), 0);
    chk("ar_flush", 64'(fpu_flush_o), 0);
    chk("ar_rdy", 64'(req_ready_o), 0);
    rst_i = 0;
    tick();
    chk("ar_rdy1", 64'(req_ready_o), 1);
    chk("ar_busy1", 64'(busy_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
